fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of one FIFO word.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i, input, N_REQ bits: per-requester write request.
REQ-006 SHALL have port req_data_i, input, N_REQ*DATA_WIDTH bits: requester k data in slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port req_ready_o, output, N_REQ bits: one-hot accept pulse.
REQ-008 SHALL have port fifo_w_en_o, output, 1 bit: drives the sync FIFO w_en.
REQ-009 SHALL have port fifo_data_o, output, DATA_WIDTH bits: drives the sync FIFO data_in.
REQ-010 SHALL have port fifo_full_i, input, 1 bit: the sync FIFO fifo_full.
REQ-011 SHALL have port grant_id_o, output, clog2(N_REQ) bits: index of the requester currently being served.
REQ-012 SHALL have port busy_o, output, 1 bit: high in ISSUE or COMMIT.
REQ-013 SHALL have port drop_o, output, 1 bit: one-cycle pulse when a write is lost to fifo_full_i.
REQ-014 SHALL have port wr_count_o, output, 16 bits: count of committed writes.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ISSUE, COMMIT.
- The FIFO registers w_en internally and samples data_in one edge later.
- Consequently data must be held for the cycle after w_en.
REQ-016 IDLE: when any req_valid_i bit is set and fifo_full_i=0, the block SHALL pick a winner round-robin, pulse req_ready_o[winner], capture its data and grant_id_o, and go to ISSUE.
- req_valid_i & req_ready_o is the handshake.
- With no request, or with fifo_full_i=1, the block SHALL stay in IDLE with req_ready_o=0.
REQ-017 ISSUE: the block SHALL drive fifo_w_en_o=1 for exactly one cycle, drive captured data on fifo_data_o, then go to COMMIT.
REQ-018 COMMIT: the block SHALL drive fifo_w_en_o=0 with fifo_data_o still holding the captured data, then go to IDLE.
- If fifo_full_i=0: wr_count_o SHALL increment (wraps 0xFFFF->0).
- Else: drop_o SHALL pulse and wr_count_o SHALL hold.
REQ-019 Round-robin: the priority pointer SHALL start at 0 and, on each accept, move to winner+1 mod N_REQ; the search SHALL begin at the pointer and ascend with wrap.
REQ-020 Throughput SHALL be at most one accepted write per 3 cycles; accept-to-w_en latency SHALL be 1 cycle.
REQ-021 Outside ISSUE/COMMIT, fifo_data_o SHALL hold the last captured value.
REQ-022 req_valid_i deasserting while not granted SHALL have no effect.
REQ-023 Data SHALL never be accepted while fifo_full_i=1.

Reset
REQ-024 resetn_i low SHALL asynchronously force the following values:
- state=IDLE, pointer=0, grant_id_o=0
- fifo_w_en_o=0, fifo_data_o=0
- req_ready_o=0, drop_o=0, busy_o=0
- wr_count_o=0
REQ-025 Reset asserted mid-ISSUE/COMMIT SHALL abandon the in-flight word without a drop_o pulse or count; operation resumes in IDLE on the first edge after release.

Structure
REQ-026 FSM state encodings (IDLE=2'd0, ISSUE=2'd1, COMMIT=2'd2) and the 16-bit counter width SHALL live in shared package fifo_arb_pkg.
REQ-027 The round-robin winner search SHALL be a sub-module rr_pick (inputs: request vector, pointer; outputs: valid, index).

Verification
REQ-028 Single requester 0 with valid held and data 0xA5A5A5A5 SHALL produce:
- req_ready_o[0] at cycle t
- fifo_w_en_o at t+1
- fifo_data_o=0xA5A5A5A5 at t+1 and t+2
- wr_count_o=1 after t+2
REQ-029 All 4 requesters valid continuously after reset SHALL produce grant order 0,1,2,3,0, with accepts spaced exactly 3 cycles apart.
REQ-030 fifo_full_i=1 while requesters 1 and 2 are valid SHALL produce no req_ready_o and fifo_w_en_o=0; releasing full SHALL grant requester 1 on the next cycle.
REQ-031 fifo_full_i forced to 1 during COMMIT only SHALL produce one drop_o pulse with wr_count_o unchanged.
REQ-032 resetn_i asserted during ISSUE SHALL produce:
- fifo_w_en_o=0 immediately (asynchronous)
- wr_count_o=0 and no drop_o pulse
- first post-release accept going to requester 0
REQ-033 Driving 65537 writes SHALL produce wr_count_o=1 (wrap check).

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   state_e : arbiter FSM encodings (IDLE / ISSUE / COMMIT)
//   CNT_W   : width of the committed-write counter
package fifo_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin winner search.
// Scans the request vector starting at the priority pointer and ascending
// with wrap-around; reports whether any request exists and the index of the
// first one found.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index where the search starts
//   valid_o : at least one request is set
//   idx_o   : index of the winning requester (0 when valid_o is low)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic             valid_o,
  output logic [IDW-1:0]   idx_o
);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the closest request to the
  // pointer is the last assignment and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr_i) + i) % N_REQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a synchronous FIFO.
// The FIFO registers w_en and samples data_in one edge later, so every
// accepted word is presented for two cycles: ISSUE (w_en=1) then COMMIT
// (w_en=0, data held). The FIFO full flag is re-examined in COMMIT to decide
// whether the word landed (count it) or was lost (pulse drop_o).
//   clk_i, resetn_i : clock, asynchronous active-low reset
//   req_valid_i     : per-requester write request
//   req_data_i      : requester k data in [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o     : one-hot accept pulse (handshake with req_valid_i)
//   fifo_w_en_o     : FIFO write enable
//   fifo_data_o     : FIFO data_in, holds the last captured word
//   fifo_full_i     : FIFO full flag
//   grant_id_o      : index of the requester being served
//   busy_o          : high in ISSUE or COMMIT
//   drop_o          : one-cycle pulse when a write is lost to full
//   wr_count_o      : committed-write counter, wraps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        fifo_w_en_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  input  logic                        fifo_full_i,
  output logic [$clog2(N_REQ)-1:0]    grant_id_o,
  output logic                        busy_o,
  output logic                        drop_o,
  output logic [CNT_W-1:0]            wr_count_o
);

  localparam int IDW = $clog2(N_REQ);

  state_e                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  pick_valid;
  logic [IDW-1:0]        pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    fifo_w_en_o = 1'b0;
    drop_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Never accept while full: the word would have nowhere to go.
        if (pick_valid && !fifo_full_i) begin
          req_ready_o = N_REQ'(1) << pick_idx;
          grant_d     = pick_idx;
          ptr_d       = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == IDW'(k)) begin
              data_d = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        fifo_w_en_o = 1'b1;
        state_d     = COMMIT;
      end

      COMMIT: begin
        // The FIFO samples data on this edge; full here means the word is lost.
        if (!fifo_full_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          drop_o = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_data_o = data_q;
  assign grant_id_o  = grant_q;
  assign wr_count_o  = cnt_q;
  assign busy_o      = (state_q != IDLE);

endmodule : fifo_wr_arbiter
